// File: rtl/counter_223_checker_if.sv
// Stimulus/response bus between the (2,2,3) counter checker and the wrapper.
//   C0 : 3 weight-1 stimulus bits    (checker -> wrapper)
//   C1 : 2 weight-2 stimulus bits    (checker -> wrapper)
//   C2 : 2 weight-4 stimulus bits    (checker -> wrapper)
//   O  : 4-bit weighted sum result   (wrapper -> checker)
interface counter_223_checker_if;
    logic [2:0] C0;
    logic [1:0] C1;
    logic [1:0] C2;
    logic [3:0] O;

    modport master (output C0, C1, C2, input O);
    modport slave  (input C0, C1, C2, output O);
endinterface

// File: rtl/counter_223_checker.sv
// Stimulus generator and response checker for a (2,2,3) generalized parallel
// counter wrapper. Drives exhaustive or LFSR vectors onto C0/C1/C2, aligns the
// golden weighted bit count with the wrapper result O after LATENCY cycles,
// and reports mismatch count plus the first failing vector.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, mode     : run request (IDLE/DONE only), 0 = exhaustive, 1 = random
//   bus             : C0/C1/C2 stimulus out, O result in
//   busy, done, pass: RUN|DRAIN, DONE, DONE with zero errors
//   err_cnt         : saturating mismatch count
//   first_fail_vec  : {C2,C1,C0} of first mismatch
//   first_fail_o    : O observed at first mismatch
module counter_223_checker #(
    parameter int unsigned LATENCY  = 2,
    parameter int unsigned NUM_RAND = 256,
    parameter logic [6:0]  SEED     = 7'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    counter_223_checker_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_cnt,
    output logic [6:0]            first_fail_vec,
    output logic [3:0]            first_fail_o
);
    localparam int unsigned VEC_W = 7;
    localparam int unsigned SUM_W = 4;
    localparam int unsigned IDX_W = 16;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ERR_W = 8;
    localparam int unsigned VP_W  = LATENCY * VEC_W;
    localparam int unsigned EP_W  = LATENCY * SUM_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [IDX_W-1:0]   idx_q, idx_d, num_vec;
    logic [VEC_W-1:0]   lfsr_q, lfsr_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [VP_W-1:0]    vpipe_q, vpipe_d;
    logic [EP_W-1:0]    epipe_q, epipe_d;
    logic [ERR_W-1:0]   err_d;
    logic [VEC_W-1:0]   ffv_d;
    logic [SUM_W-1:0]   ffo_d;
    logic               busy_d, done_d, pass_d;
    logic               issue, clear, mismatch;
    logic [VEC_W-1:0]   tap_vec;
    logic [SUM_W-1:0]   tap_exp;

    // Golden value: popcount(C0) + 2*popcount(C1) + 4*popcount(C2), max 15.
    function automatic logic [SUM_W-1:0] weighted_sum(input logic [VEC_W-1:0] v);
        return SUM_W'(v[0]) + SUM_W'(v[1]) + SUM_W'(v[2])
             + {2'b00, v[3], 1'b0} + {2'b00, v[4], 1'b0}
             + {1'b0, v[5], 2'b00} + {1'b0, v[6], 2'b00};
    endfunction

    // Fibonacci LFSR x^7 + x^6 + 1.
    function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] q);
        return {q[5:0], q[6] ^ q[5]};
    endfunction

    assign bus.C0 = vec_q[2:0];
    assign bus.C1 = vec_q[4:3];
    assign bus.C2 = vec_q[6:5];

    // Oldest pipe stage lines up with the wrapper result for the same vector.
    assign tap_vec  = vpipe_q[VP_W-1 -: VEC_W];
    assign tap_exp  = epipe_q[EP_W-1 -: SUM_W];
    assign mismatch = vld_q[LATENCY-1] && (bus.O != tap_exp);

    // Next-state, vector issue, alignment pipes and result bookkeeping.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        lfsr_d  = lfsr_q;
        drain_d = drain_q;
        vec_d   = '0;
        issue   = 1'b0;
        clear   = 1'b0;
        num_vec = mode_q ? IDX_W'(NUM_RAND) : IDX_W'(128);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    mode_d  = mode;
                    issue   = 1'b1;
                    vec_d   = mode ? SEED : '0;
                    lfsr_d  = lfsr_next(SEED);
                    idx_d   = IDX_W'(1);
                end
            end
            RUN: begin
                if (idx_q == num_vec) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    issue  = 1'b1;
                    vec_d  = mode_q ? lfsr_q : idx_q[VEC_W-1:0];
                    lfsr_d = lfsr_next(lfsr_q);
                    idx_d  = idx_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == CNT_W'(LATENCY - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Width casts drop the oldest stage; a new run flushes stale valids.
        vld_d   = clear ? LATENCY'(issue) : LATENCY'({vld_q, issue});
        vpipe_d = VP_W'({vpipe_q, vec_d});
        epipe_d = EP_W'({epipe_q, weighted_sum(vec_d)});

        err_d = err_cnt;
        ffv_d = first_fail_vec;
        ffo_d = first_fail_o;
        if (clear) begin
            err_d = '0;
            ffv_d = '0;
            ffo_d = '0;
        end else if (mismatch) begin
            // err_cnt == 0 means nothing has been recorded yet this run.
            if (err_cnt == '0) begin
                ffv_d = tap_vec;
                ffo_d = bus.O;
            end
            if (err_cnt != '1) begin
                err_d = err_cnt + ERR_W'(1);
            end
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = done_d && (err_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            mode_q         <= 1'b0;
            idx_q          <= '0;
            lfsr_q         <= SEED;
            drain_q        <= '0;
            vec_q          <= '0;
            vld_q          <= '0;
            vpipe_q        <= '0;
            epipe_q        <= '0;
            err_cnt        <= '0;
            first_fail_vec <= '0;
            first_fail_o   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            idx_q          <= idx_d;
            lfsr_q         <= lfsr_d;
            drain_q        <= drain_d;
            vec_q          <= vec_d;
            vld_q          <= vld_d;
            vpipe_q        <= vpipe_d;
            epipe_q        <= epipe_d;
            err_cnt        <= err_d;
            first_fail_vec <= ffv_d;
            first_fail_o   <= ffo_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
        end
    end
endmodule

// File: tb/tb_counter_223_checker.sv
// Testbench for counter_223_checker: two checker instances (LATENCY 2 and 3)
// each drive a behavioural wrapper model with selectable latency and fault.
// Expected stimulus and end-of-run results are queued at start and checked by
// per-instance monitors.
module tb_counter_223_checker;
    localparam logic [6:0] SEED = 7'h5A;
    localparam int NI = 2;

    typedef struct packed {
        logic [7:0]  err;
        logic [6:0]  ffv;
        logic [3:0]  ffo;
        logic        pass;
        logic [31:0] cyc;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, mode;
    logic       busy [NI];
    logic       done [NI];
    logic       pass [NI];
    logic [7:0] err_cnt [NI];
    logic [6:0] ffv [NI];
    logic [3:0] ffo [NI];
    logic [6:0] cvec [NI];
    int         model_lat [NI];
    int         fault [NI];
    logic [6:0] vec_q [NI][$];
    res_t       res_q [NI][$];
    int         tests = 0;
    int         fails = 0;

    function automatic logic [3:0] wsum(input logic [6:0] v);
        int s = 0;
        for (int i = 0; i < 7; i++) begin
            if (v[i]) s += (i < 3) ? 1 : ((i < 5) ? 2 : 4);
        end
        return 4'(s);
    endfunction

    // Wrapper output: 0 = correct, 1 = O[0] stuck at 0, 2 = inverted.
    function automatic logic [3:0] wrap_out(input logic [6:0] v, input int flt);
        logic [3:0] s;
        s = wsum(v);
        if (flt == 1) s = s & 4'hE;
        else if (flt == 2) s = ~s;
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference result: the checker compares vector k against the wrapper's
    // response to vector k + L - mlat (zero stimulus outside the run).
    function automatic res_t ref_run(input logic [6:0] v[$], input int L,
                                     input int mlat, input int flt);
        res_t r;
        int   n, j;
        logic [6:0] seen;
        logic [3:0] o;
        n = v.size();
        r = '0;
        for (int k = 0; k < n; k++) begin
            j = k + L - mlat;
            seen = (j < 0 || j >= n) ? 7'd0 : v[j];
            o = wrap_out(seen, flt);
            if (o != wsum(v[k])) begin
                if (r.err == 8'd0) begin
                    r.ffv = v[k];
                    r.ffo = o;
                end
                if (r.err != 8'd255) r.err = r.err + 8'd1;
            end
        end
        r.pass = (r.err == 8'd0);
        r.cyc  = 32'(n + L);
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        counter_223_checker_if bus ();
        logic [6:0] hist [8];
        int   bcnt;
        logic bprev, dprev;

        counter_223_checker #(
            .LATENCY  (2 + g),
            .NUM_RAND ((g == 0) ? 300 : 50),
            .SEED     (SEED)
        ) dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .start          (start),
            .mode           (mode),
            .bus            (bus),
            .busy           (busy[g]),
            .done           (done[g]),
            .pass           (pass[g]),
            .err_cnt        (err_cnt[g]),
            .first_fail_vec (ffv[g]),
            .first_fail_o   (ffo[g])
        );

        assign cvec[g] = {bus.C2, bus.C1, bus.C0};

        // Wrapper model: model_lat-1 register stages after C.
        always @(posedge clk) begin
            hist[0] <= cvec[g];
            for (int i = 1; i < 8; i++) hist[i] <= hist[i-1];
        end

        always_comb begin
            logic [6:0] d;
            d = (model_lat[g] <= 1) ? cvec[g] : hist[3'(model_lat[g] - 2)];
            bus.O = wrap_out(d, fault[g]);
        end

        // Monitor: stimulus while busy, final results on done rising.
        always @(negedge clk) begin
            if (!rst_n) begin
                bcnt  = 0;
                bprev = 1'b0;
                dprev = 1'b0;
            end else begin
                if (busy[g]) bcnt = bprev ? bcnt + 1 : 1;
                if (busy[g] && vec_q[g].size() > 0) begin
                    check($sformatf("i%0d_stim", g), int'(cvec[g]), int'(vec_q[g].pop_front()));
                end
                if (done[g] && !dprev) begin
                    check($sformatf("i%0d_done_expected", g), int'(res_q[g].size() > 0), 1);
                    if (res_q[g].size() > 0) begin
                        res_t r;
                        r = res_q[g].pop_front();
                        check($sformatf("i%0d_err_cnt", g), int'(err_cnt[g]), int'(r.err));
                        check($sformatf("i%0d_first_fail_vec", g), int'(ffv[g]), int'(r.ffv));
                        check($sformatf("i%0d_first_fail_o", g), int'(ffo[g]), int'(r.ffo));
                        check($sformatf("i%0d_pass", g), int'(pass[g]), int'(r.pass));
                        check($sformatf("i%0d_run_cycles", g), bcnt, int'(r.cyc));
                    end
                end
                bprev = busy[g];
                dprev = done[g];
            end
        end
    end

    task automatic set_model(input int g, input int mlat, input int flt);
        model_lat[g] = mlat;
        fault[g]     = flt;
    endtask

    task automatic launch(input int m);
        for (int g = 0; g < NI; g++) begin
            logic [6:0] v[$];
            logic [6:0] lf;
            int n;
            v.delete();
            n  = (m != 0) ? ((g == 0) ? 300 : 50) : 128;
            lf = SEED;
            for (int k = 0; k < n; k++) begin
                v.push_back((m != 0) ? lf : 7'(k));
                lf = {lf[5:0], lf[6] ^ lf[5]};
            end
            foreach (v[k]) vec_q[g].push_back(v[k]);
            res_q[g].push_back(ref_run(v, 2 + g, model_lat[g], fault[g]));
        end
        mode  = m[0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int c = 0;
        while (!(done[0] && done[1]) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("run_timeout", int'(c < 3000), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("%s_i%0d_busy", tag, g), int'(busy[g]), 0);
            check($sformatf("%s_i%0d_done", tag, g), int'(done[g]), 0);
            check($sformatf("%s_i%0d_pass", tag, g), int'(pass[g]), 0);
            check($sformatf("%s_i%0d_err", tag, g), int'(err_cnt[g]), 0);
            check($sformatf("%s_i%0d_ffv", tag, g), int'(ffv[g]), 0);
            check($sformatf("%s_i%0d_ffo", tag, g), int'(ffo[g]), 0);
            check($sformatf("%s_i%0d_c", tag, g), int'(cvec[g]), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        mode  = 1'b0;
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 0);

        // Reset held with start asserted: reset wins.
        repeat (10) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("post_reset_i%0d_done", g), int'(done[g]), 0);
            check($sformatf("post_reset_i%0d_busy", g), int'(busy[g]), 0);
        end

        // Exhaustive with correct wrapper.
        launch(0);
        wait_done();

        // O[0] stuck at 0.
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 1);
        launch(0);
        wait_done();

        // Wrapper latency 3: mismatched for LATENCY=2, matched for LATENCY=3.
        for (int g = 0; g < NI; g++) set_model(g, 3, 0);
        launch(0);
        wait_done();

        // Inverted output in random mode: saturation on the 300-vector instance.
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 2);
        launch(1);
        wait_done();

        // Randomised runs, including immediate restart from DONE.
        for (int r = 0; r < 6; r++) begin
            for (int g = 0; g < NI; g++) begin
                set_model(g, 2 + g + int'($urandom_range(0, 2)) - 1, int'($urandom_range(0, 2)));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            launch(int'($urandom_range(0, 1)));
            wait_done();
        end

        // Start pulsed mid-run is ignored.
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 0);
        launch(0);
        repeat (20) @(posedge clk);
        #1;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();

        // Reset mid-run clears everything; next run is clean.
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 2);
        launch(1);
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int g = 0; g < NI; g++) begin
            vec_q[g].delete();
            res_q[g].delete();
        end
        #1;
        check_outputs_zero("midrun_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < NI; g++) begin
            check($sformatf("after_midrun_i%0d_busy", g), int'(busy[g]), 0);
            check($sformatf("after_midrun_i%0d_done", g), int'(done[g]), 0);
        end
        repeat (10) @(posedge clk);
        #1;
        for (int g = 0; g < NI; g++) set_model(g, 2 + g, 0);
        launch(0);
        wait_done();
        for (int g = 0; g < NI; g++) check($sformatf("final_i%0d_pass", g), int'(pass[g]), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
